// File: rtl/commit_monitor.sv
// commit_monitor: watches the retire stream of the single-cycle core.
// It counts retired instructions and elapsed cycles, and it flags PCs that
// are misaligned or that do not match the reset vector. The run ends when the
// core sits on one PC (HALTED) or when a cycle budget expires (TIMEOUT).
//
// Handshake: i_insn_vld is a plain qualifier with no ready/backpressure.
// The block samples i_pc_debug on every rising edge where i_insn_vld=1, and
// it can never stall the core.
//
// o_state is the FSM state register, brought out directly for debug and
// checker binding. Every output comes from a register. o_done is decoded from
// that state register only.
module commit_monitor #(
  parameter logic [31:0] PC_RESET    = 32'h0000_0000,
  parameter int unsigned HALT_REPEAT = 4,
  parameter int unsigned TIMEOUT_CYC = 5000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic [31:0]      i_pc_debug,
  input  logic             i_insn_vld,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_insn_cnt,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [31:0]      o_last_pc,
  output logic             o_pc_err,
  output logic             o_done
);

  // rep holds the number of consecutive commits at the same PC.
  // It never exceeds HALT_REPEAT.
  localparam int unsigned REP_W = $clog2(HALT_REPEAT + 1);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);
  localparam logic [REP_W-1:0] REP_HALT = REP_W'(HALT_REPEAT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_HALTED  = 2'b10,
    ST_TIMEOUT = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] insn_cnt_q, insn_cnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0]      last_pc_q, last_pc_d;
  logic             pc_err_q, pc_err_d;
  logic [REP_W-1:0] rep_q, rep_d;

  logic             live;
  logic             misaligned;

  // A run is live while counting in IDLE or RUN.
  // HALTED and TIMEOUT hold every register until clear or reset.
  assign live       = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign misaligned = (i_pc_debug[1:0] != 2'b00);

  // Next-state, counter, and flag update.
  // Clear has top priority. Within a live run, a halt beats a timeout.
  always_comb begin
    state_d     = state_q;
    insn_cnt_d  = insn_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    last_pc_d   = last_pc_q;
    pc_err_d    = pc_err_q;
    rep_d       = rep_q;

    if (i_clr) begin
      state_d     = ST_IDLE;
      insn_cnt_d  = '0;
      cycle_cnt_d = '0;
      last_pc_d   = '0;
      pc_err_d    = 1'b0;
      rep_d       = '0;
    end else if (live) begin
      if (cycle_cnt_q != CNT_MAX) begin
        cycle_cnt_d = cycle_cnt_q + CNT_ONE;
      end

      if (i_insn_vld) begin
        last_pc_d = i_pc_debug;
        if (misaligned) begin
          pc_err_d = 1'b1;
        end
        if (state_q == ST_IDLE) begin
          // The first commit of a run must land on the reset vector.
          insn_cnt_d = CNT_ONE;
          rep_d      = REP_ONE;
          state_d    = ST_RUN;
          if (i_pc_debug != PC_RESET) begin
            pc_err_d = 1'b1;
          end
        end else begin
          if (insn_cnt_q != CNT_MAX) begin
            insn_cnt_d = insn_cnt_q + CNT_ONE;
          end
          // Bubbles leave rep alone. Only a commit at a different PC resets it.
          rep_d = (i_pc_debug == last_pc_q) ? (rep_q + REP_ONE) : REP_ONE;
        end
      end

      // rep_d reaches HALT_REPEAT only through a RUN-state commit,
      // because HALT_REPEAT >= 2.
      if (rep_d == REP_HALT) begin
        state_d = ST_HALTED;
      end else if (cycle_cnt_q == TMO_LAST) begin
        state_d = ST_TIMEOUT;
      end
    end
  end

  // State and datapath registers. Reset is asynchronous and active-low.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= ST_IDLE;
      insn_cnt_q  <= '0;
      cycle_cnt_q <= '0;
      last_pc_q   <= '0;
      pc_err_q    <= 1'b0;
      rep_q       <= '0;
    end else begin
      state_q     <= state_d;
      insn_cnt_q  <= insn_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      last_pc_q   <= last_pc_d;
      pc_err_q    <= pc_err_d;
      rep_q       <= rep_d;
    end
  end

  assign o_state     = state_q;
  assign o_insn_cnt  = insn_cnt_q;
  assign o_cycle_cnt = cycle_cnt_q;
  assign o_last_pc   = last_pc_q;
  assign o_pc_err    = pc_err_q;
  assign o_done      = (state_q == ST_HALTED) || (state_q == ST_TIMEOUT);

endmodule

// File: tb/tb_commit_monitor.sv
// Bench for commit_monitor. Two instances share every input:
//   dut_a uses the default 5000-cycle timeout.
//   dut_t uses a 20-cycle timeout.
// Each step does three things: it drives the inputs, it pushes one predicted
// snapshot per DUT to that DUT's queue, and after the edge it pops the
// snapshot and compares it with the DUT outputs.
// Directed constant checks back up the spec scenarios.
module tb_commit_monitor;

  localparam int TMO_T = 20;
  localparam int SW    = 100; // {state[2], insn[32], cycle[32], last_pc[32], err, done}

  logic        clk;
  logic        rst;
  logic        clr;
  logic [31:0] pc;
  logic        vld;

  logic [1:0]  a_state, t_state;
  logic [31:0] a_insn, t_insn, a_cyc, t_cyc, a_pc, t_pc;
  logic        a_err, t_err, a_done, t_done;

  int n_cmp = 0;
  int n_err = 0;

  logic [SW-1:0] exp_a[$];
  logic [SW-1:0] exp_t[$];

  // Reference model state. Index 0 is dut_a and index 1 is dut_t.
  logic [1:0]  m_state [2];
  logic [31:0] m_insn  [2];
  logic [31:0] m_cyc   [2];
  logic [31:0] m_pc    [2];
  logic        m_err   [2];
  int          m_rep   [2];
  int          m_tmo   [2];

  commit_monitor dut_a (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_pc_debug(pc), .i_insn_vld(vld),
    .o_state(a_state), .o_insn_cnt(a_insn), .o_cycle_cnt(a_cyc),
    .o_last_pc(a_pc), .o_pc_err(a_err), .o_done(a_done)
  );

  commit_monitor #(.TIMEOUT_CYC(TMO_T)) dut_t (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_pc_debug(pc), .i_insn_vld(vld),
    .o_state(t_state), .o_insn_cnt(t_insn), .o_cycle_cnt(t_cyc),
    .o_last_pc(t_pc), .o_pc_err(t_err), .o_done(t_done)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 2'b00;
      m_insn[k]  = '0;
      m_cyc[k]   = '0;
      m_pc[k]    = '0;
      m_err[k]   = 1'b0;
      m_rep[k]   = 0;
    end
  endtask

  // One clock edge of the monitor's intended behaviour for instance k.
  task automatic model_edge(input int k, input logic v, input logic [31:0] p, input logic c);
    logic hit;
    logic halt;
    if (c) begin
      m_state[k] = 2'b00;
      m_insn[k]  = '0;
      m_cyc[k]   = '0;
      m_pc[k]    = '0;
      m_err[k]   = 1'b0;
      m_rep[k]   = 0;
    end else if (m_state[k] == 2'b00 || m_state[k] == 2'b01) begin
      hit  = (m_cyc[k] == 32'(m_tmo[k] - 1));
      halt = 1'b0;
      if (m_cyc[k] != 32'hFFFF_FFFF) m_cyc[k] = m_cyc[k] + 1;
      if (v) begin
        if (p[1:0] != 2'b00) m_err[k] = 1'b1;
        if (m_state[k] == 2'b00) begin
          if (p != 32'h0) m_err[k] = 1'b1;
          m_insn[k]  = 1;
          m_rep[k]   = 1;
          m_state[k] = 2'b01;
        end else begin
          if (m_insn[k] != 32'hFFFF_FFFF) m_insn[k] = m_insn[k] + 1;
          m_rep[k] = (p == m_pc[k]) ? m_rep[k] + 1 : 1;
          if (m_rep[k] == 4) halt = 1'b1;
        end
        m_pc[k] = p;
      end
      if (halt) m_state[k] = 2'b10;
      else if (hit) m_state[k] = 2'b11;
    end
  endtask

  function automatic logic [SW-1:0] snap(input int k);
    return {m_state[k], m_insn[k], m_cyc[k], m_pc[k], m_err[k], m_state[k][1]};
  endfunction

  task automatic check_snap(input string who, input logic [SW-1:0] e,
                            input logic [1:0] st, input logic [31:0] ic, input logic [31:0] cc,
                            input logic [31:0] lp, input logic er, input logic dn);
    cmp({who, ".state"},   32'(st), 32'(e[99:98]));
    cmp({who, ".insn"},    ic, e[97:66]);
    cmp({who, ".cycle"},   cc, e[65:34]);
    cmp({who, ".last_pc"}, lp, e[33:2]);
    cmp({who, ".pc_err"},  32'(er), 32'(e[1]));
    cmp({who, ".done"},    32'(dn), 32'(e[0]));
  endtask

  // Drive at the falling edge, predict, wait for the edge, then compare at the next falling edge.
  task automatic step(input logic v, input logic [31:0] p, input logic c);
    vld = v;
    pc  = p;
    clr = c;
    model_edge(0, v, p, c);
    model_edge(1, v, p, c);
    exp_a.push_back(snap(0));
    exp_t.push_back(snap(1));
    @(posedge clk);
    @(negedge clk);
    if (exp_a.size() == 0 || exp_t.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL queue_empty: observed 0 expected 1");
    end else begin
      check_snap("a", exp_a.pop_front(), a_state, a_insn, a_cyc, a_pc, a_err, a_done);
      check_snap("t", exp_t.pop_front(), t_state, t_insn, t_cyc, t_pc, t_err, t_done);
    end
  endtask

  initial begin
    m_tmo[0] = 5000;
    m_tmo[1] = TMO_T;
    model_reset();
    rst = 1'b0;
    clr = 1'b0;
    vld = 1'b0;
    pc  = '0;
    repeat (2) @(negedge clk);
    cmp("rst.a_state", 32'(a_state), 32'h0);
    cmp("rst.a_done",  32'(a_done),  32'h0);
    rst = 1'b1;

    // Sequential commits 0x00..0x1C
    for (int i = 0; i < 8; i++) step(1'b1, 32'(i * 4), 1'b0);
    cmp("seq.state",   32'(a_state), 32'h1);
    cmp("seq.insn",    a_insn,       32'd8);
    cmp("seq.last_pc", a_pc,         32'h1C);
    cmp("seq.pc_err",  32'(a_err),   32'h0);

    // Halt on four commits at 0x20, with bubbles in between
    step(1'b1, 32'h20, 1'b0);
    step(1'b0, 32'h0,  1'b0);
    step(1'b1, 32'h20, 1'b0);
    step(1'b1, 32'h20, 1'b0);
    cmp("halt.pre_state", 32'(a_state), 32'h1);
    step(1'b0, 32'h0,  1'b0);
    step(1'b1, 32'h20, 1'b0);
    cmp("halt.state", 32'(a_state), 32'h2);
    cmp("halt.insn",  a_insn,       32'd12);
    cmp("halt.done",  32'(a_done),  32'h1);
    step(1'b1, 32'h24, 1'b0);
    step(1'b1, 32'h28, 1'b0);
    cmp("halt.frozen_insn", a_insn, 32'd12);

    // PC errors: the first PC is not the reset vector, or a PC is misaligned
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h4, 1'b0);
    cmp("err.first_pc", 32'(a_err), 32'h1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h0, 1'b0);
    cmp("err.clean_start", 32'(a_err), 32'h0);
    step(1'b1, 32'h6, 1'b0);
    cmp("err.misaligned", 32'(a_err), 32'h1);
    step(1'b1, 32'h8, 1'b0);
    cmp("err.sticky", 32'(a_err), 32'h1);

    // Clear beats a same-cycle commit while in RUN
    step(1'b1, 32'hC, 1'b1);
    cmp("clr.state", 32'(a_state), 32'h0);
    cmp("clr.insn",  a_insn,       32'h0);
    cmp("clr.cycle", a_cyc,        32'h0);
    cmp("clr.pc",    a_pc,         32'h0);

    // Timeout with no commits
    for (int i = 0; i < TMO_T; i++) step(1'b0, 32'h0, 1'b0);
    cmp("tmo_idle.state", 32'(t_state), 32'h3);
    cmp("tmo_idle.cycle", t_cyc,        32'd20);
    cmp("tmo_idle.a_state", 32'(a_state), 32'h0);
    step(1'b1, 32'h10, 1'b0);
    cmp("tmo_idle.frozen_insn",  t_insn, 32'h0);
    cmp("tmo_idle.frozen_cycle", t_cyc,  32'd20);

    // Timeout while commits alternate between 0x10 and 0x14
    step(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < TMO_T; i++) step(1'b1, (i % 2 == 1) ? 32'h14 : 32'h10, 1'b0);
    cmp("tmo_run.state",   32'(t_state), 32'h3);
    cmp("tmo_run.insn",    t_insn,       32'd20);
    cmp("tmo_run.last_pc", t_pc,         32'h14);
    cmp("tmo_run.pc_err",  32'(t_err),   32'h1);

    // Halt and timeout on the same edge: HALTED wins
    step(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h0, 1'b0);
    cmp("tie.state", 32'(t_state), 32'h2);
    cmp("tie.cycle", t_cyc,        32'd20);
    cmp("tie.insn",  t_insn,       32'd4);

    // Asynchronous reset in the middle of a cycle
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h0, 1'b0);
    step(1'b1, 32'h4, 1'b0);
    vld = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    cmp("arst.a_state", 32'(a_state), 32'h0);
    cmp("arst.a_insn",  a_insn,       32'h0);
    cmp("arst.a_cycle", a_cyc,        32'h0);
    cmp("arst.a_pc",    a_pc,         32'h0);
    cmp("arst.a_err",   32'(a_err),   32'h0);
    cmp("arst.t_done",  32'(t_done),  32'h0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    step(1'b1, 32'h0, 1'b0);
    cmp("arst.restart_insn", a_insn, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
